mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 36 +++
 rtl/mem_lane_align.sv | 40 ++++
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and helpers for the memory arbiter
package mem_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    typedef struct packed {
        logic [31:0] word;
        logic [1:0]  off;
        logic [1:0]  size;
        logic [31:0] wdata;
    } merge_t;

    // Size code 3 is treated as a word everywhere (size[1] set).
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == SZ_H) && off[0]) || (is_word(size) && (off != 2'd0));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane store merge and load extraction/extension
module mem_lane_align
    import mem_arbiter_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b    = rd_word[{off, 3'b000} +: 8];
        lane_h    = rd_word[{off[1], 4'b0000} +: 16];
        load_data = rd_word;
        merged    = wdata;
        case (size)
            SZ_B: begin
                load_data = is_unsigned ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
                merged    = rd_word;
                merged[{off, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_H: begin
                load_data = is_unsigned ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
                merged    = rd_word;
                merged[{off[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_data = rd_word;
                merged    = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/data arbiter onto one memory port with sub-word read-modify-write
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_req_i,
    input  logic [AWIDTH-1:0] imem_addr_i,
    output logic              imem_gnt_o,
    output logic              imem_rvalid_o,
    output logic [DWIDTH-1:0] imem_rdata_o,
    input  logic              dmem_req_i,
    input  logic              dmem_we_i,
    input  logic [1:0]        dmem_size_i,
    input  logic              dmem_unsigned_i,
    input  logic [AWIDTH-1:0] dmem_addr_i,
    input  logic [DWIDTH-1:0] dmem_wdata_i,
    output logic              dmem_gnt_o,
    output logic              dmem_rvalid_o,
    output logic [DWIDTH-1:0] dmem_rdata_o,
    output logic              dmem_err_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_data_i
);

    state_t            state;
    state_t            state_nxt;
    owner_t            last_own;
    merge_t            mb;
    logic [AWIDTH-1:0] mb_addr;

    logic              d_misal;
    logic              d_word;
    logic              d_load_gnt;
    logic              d_rmw_gnt;
    logic [AWIDTH-1:0] i_waddr;
    logic [AWIDTH-1:0] d_waddr;

    logic [31:0]       al_rd_word;
    logic [31:0]       al_wdata;
    logic [1:0]        al_off;
    logic [1:0]        al_size;
    logic [31:0]       load_data;
    logic [31:0]       merged;

    logic              unused;
    assign unused = ^imem_addr_i[1:0];

    assign i_waddr    = {imem_addr_i[AWIDTH-1:2], 2'b00};
    assign d_waddr    = {dmem_addr_i[AWIDTH-1:2], 2'b00};
    assign d_misal    = misaligned(dmem_size_i, dmem_addr_i[1:0]);
    assign d_word     = is_word(dmem_size_i);
    assign d_load_gnt = dmem_gnt_o && !dmem_we_i && !d_misal;
    assign d_rmw_gnt  = dmem_gnt_o && dmem_we_i && !d_misal && !d_word;

    // One aligner serves both cycles: the live load in IDLE, the buffered merge in RMW_WR.
    always_comb begin
        if (state == RMW_WR) begin
            al_rd_word = mb.word;
            al_wdata   = mb.wdata;
            al_off     = mb.off;
            al_size    = mb.size;
        end else begin
            al_rd_word = mem_data_i;
            al_wdata   = dmem_wdata_i;
            al_off     = dmem_addr_i[1:0];
            al_size    = dmem_size_i;
        end
    end

    mem_lane_align u_align (
        .rd_word     (al_rd_word),
        .wdata       (al_wdata),
        .off         (al_off),
        .size        (al_size),
        .is_unsigned (dmem_unsigned_i),
        .load_data   (load_data),
        .merged      (merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (d_rmw_gnt) state_nxt = RMW_WR;
            RMW_WR:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_gnt_o     = 1'b0;
        dmem_gnt_o     = 1'b0;
        mem_addr_o     = '0;
        mem_data_o     = '0;
        mem_read_en_o  = 1'b0;
        mem_write_en_o = 1'b0;
        if (!rst) begin
            if (state == RMW_WR) begin
                mem_addr_o     = mb_addr;
                mem_data_o     = merged;
                mem_write_en_o = 1'b1;
            end else begin
                // Fetch loses a tie unless data won the previous grant.
                imem_gnt_o = imem_req_i && (!dmem_req_i || (last_own == OWN_D));
                dmem_gnt_o = dmem_req_i && !imem_gnt_o;
                if (imem_gnt_o) begin
                    mem_addr_o    = i_waddr;
                    mem_read_en_o = 1'b1;
                end else if (dmem_gnt_o && !d_misal) begin
                    mem_addr_o = d_waddr;
                    if (dmem_we_i && d_word) begin
                        mem_data_o     = dmem_wdata_i;
                        mem_write_en_o = 1'b1;
                    end else begin
                        mem_read_en_o = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_own      <= OWN_I;
            imem_rvalid_o <= 1'b0;
            imem_rdata_o  <= '0;
            dmem_rvalid_o <= 1'b0;
            dmem_rdata_o  <= '0;
            dmem_err_o    <= 1'b0;
            mb            <= '0;
            mb_addr       <= '0;
        end else begin
            imem_rvalid_o <= imem_gnt_o;
            dmem_rvalid_o <= d_load_gnt;
            dmem_err_o    <= dmem_gnt_o && d_misal;
            if (imem_gnt_o) begin
                imem_rdata_o <= mem_data_i;
                last_own     <= OWN_I;
            end else if (dmem_gnt_o) begin
                last_own     <= OWN_D;
            end
            if (d_load_gnt) begin
                dmem_rdata_o <= load_data;
            end
            if (d_rmw_gnt) begin
                mb      <= '{word: mem_data_i, off: dmem_addr_i[1:0], size: dmem_size_i, wdata: dmem_wdata_i};
                mb_addr <= d_waddr;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a byte-level memory model
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [1:0]  dmem_size;
    logic        dmem_unsigned;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        dmem_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_rdata;

    mem_arbiter #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_i      (imem_req),
        .imem_addr_i     (imem_addr),
        .imem_gnt_o      (imem_gnt),
        .imem_rvalid_o   (imem_rvalid),
        .imem_rdata_o    (imem_rdata),
        .dmem_req_i      (dmem_req),
        .dmem_we_i       (dmem_we),
        .dmem_size_i     (dmem_size),
        .dmem_unsigned_i (dmem_unsigned),
        .dmem_addr_i     (dmem_addr),
        .dmem_wdata_i    (dmem_wdata),
        .dmem_gnt_o      (dmem_gnt),
        .dmem_rvalid_o   (dmem_rvalid),
        .dmem_rdata_o    (dmem_rdata),
        .dmem_err_o      (dmem_err),
        .mem_addr_o      (mem_addr),
        .mem_data_o      (mem_wdata),
        .mem_read_en_o   (mem_read_en),
        .mem_write_en_o  (mem_write_en),
        .mem_data_i      (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] phys [int unsigned];
    logic [7:0]  rmem [int unsigned];

    logic        m_last_d = 1'b0;
    logic        m_busy = 1'b0;
    logic [31:0] m_busy_addr = 0;
    logic [31:0] m_st_addr = 0;
    logic [1:0]  m_st_size = 0;
    logic [31:0] m_st_wdata = 0;
    logic        e_irv = 0, e_drv = 0, e_derr = 0;
    logic [31:0] e_ird = 0, e_drd = 0;
    logic        g_i, g_d;
    logic        s_ig, s_dg, s_we;
    logic [31:0] s_addr, s_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] wa);
        return (wa * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] wa);
        if (phys.exists(wa)) return phys[wa];
        return init_word(wa);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        logic [31:0] w;
        if (rmem.exists(a)) return rmem[a];
        w = init_word(a & ~32'd3) >> (8 * (a % 4));
        return w[7:0];
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] wa);
        return {ref_byte(wa + 3), ref_byte(wa + 2), ref_byte(wa + 1), ref_byte(wa)};
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        int n;
        logic [31:0] v;
        n = 1 << sz;
        v = 0;
        for (int k = 0; k < n; k++) v = v | (32'(ref_byte(a + k)) << (8 * k));
        if (!uns && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] t;
        for (int k = 0; k < (1 << sz); k++) begin
            t = wd >> (8 * k);
            rmem[a + k] = t[7:0];
        end
    endtask

    task automatic preload(input logic [31:0] wa, input logic [31:0] w);
        phys[wa] = w;
        ref_store(wa, 2'd2, w);
    endtask

    // One clock: inputs already set at negedge; check comb outputs, then registered outputs after posedge.
    task automatic cycle();
        logic e_ig, e_dg, e_re, e_we, mis;
        logic [31:0] e_addr, e_data, wa;
        logic n_irv, n_drv, n_derr;
        logic [31:0] n_ird, n_drd;
        #1;
        mem_rdata = mem_read_en ? phys_rd(mem_addr) : $urandom;
        #1;
        e_ig = 0; e_dg = 0; e_re = 0; e_we = 0; e_addr = 0; e_data = 0;
        n_irv = 0; n_drv = 0; n_derr = 0; n_ird = e_ird; n_drd = e_drd;
        if (rst) begin
            m_busy = 0; m_last_d = 0; n_ird = 0; n_drd = 0;
        end else if (m_busy) begin
            ref_store(m_st_addr, m_st_size, m_st_wdata);
            e_we = 1; e_addr = m_busy_addr; e_data = ref_word(m_busy_addr);
            m_busy = 0;
        end else begin
            e_ig = imem_req && (!dmem_req || m_last_d);
            e_dg = dmem_req && !e_ig;
            if (e_ig) begin
                e_re = 1; e_addr = imem_addr & ~32'd3;
                n_irv = 1; n_ird = ref_word(e_addr); m_last_d = 0;
            end
            if (e_dg) begin
                m_last_d = 1;
                wa = dmem_addr & ~32'd3;
                mis = (dmem_size == 2'd1 && dmem_addr[0]) || (dmem_size == 2'd2 && dmem_addr[1:0] != 2'd0);
                if (mis) begin
                    n_derr = 1;
                end else if (!dmem_we) begin
                    e_re = 1; e_addr = wa; n_drv = 1;
                    n_drd = ref_load(dmem_addr, dmem_size, dmem_unsigned);
                end else if (dmem_size == 2'd2) begin
                    ref_store(dmem_addr, dmem_size, dmem_wdata);
                    e_we = 1; e_addr = wa; e_data = dmem_wdata;
                end else begin
                    e_re = 1; e_addr = wa;
                    m_busy = 1; m_busy_addr = wa;
                    m_st_addr = dmem_addr; m_st_size = dmem_size; m_st_wdata = dmem_wdata;
                end
            end
        end
        g_i = e_ig; g_d = e_dg;
        s_ig = imem_gnt; s_dg = dmem_gnt; s_we = mem_write_en; s_addr = mem_addr; s_data = mem_wdata;
        check("imem_gnt", 32'(imem_gnt), 32'(e_ig));
        check("dmem_gnt", 32'(dmem_gnt), 32'(e_dg));
        check("mem_read_en", 32'(mem_read_en), 32'(e_re));
        check("mem_write_en", 32'(mem_write_en), 32'(e_we));
        check("mem_addr", mem_addr, e_addr);
        if (e_we) check("mem_data", mem_wdata, e_data);
        if (mem_write_en) phys[mem_addr] = mem_wdata;
        @(posedge clk);
        #1;
        e_irv = n_irv; e_ird = n_ird; e_drv = n_drv; e_drd = n_drd; e_derr = n_derr;
        check("imem_rvalid", 32'(imem_rvalid), 32'(e_irv));
        check("imem_rdata", imem_rdata, e_ird);
        check("dmem_rvalid", 32'(dmem_rvalid), 32'(e_drv));
        check("dmem_rdata", dmem_rdata, e_drd);
        check("dmem_err", 32'(dmem_err), 32'(e_derr));
        @(negedge clk);
    endtask

    task automatic set_d(input logic req, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        dmem_req = req; dmem_we = we; dmem_size = sz; dmem_unsigned = uns; dmem_addr = a; dmem_wdata = wd;
    endtask

    logic [1:0] rr_seen [4];

    initial begin
        rst = 1; imem_req = 0; imem_addr = 0; mem_rdata = 0;
        set_d(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        cycle();
        cycle();
        rst = 0;

        preload(32'h0100_0004, 32'h00A0_0093);
        imem_req = 1; imem_addr = 32'h0100_0004;
        cycle();
        check("s1_gnt", 32'(s_ig), 32'd1);
        check("s1_rdata", imem_rdata, 32'h00A0_0093);
        imem_req = 0;
        cycle();

        rst = 1; cycle(); rst = 0;
        imem_req = 1; imem_addr = 32'h0100_0020;
        set_d(1, 0, 2'd2, 0, 32'h0100_0024, 0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            rr_seen[k] = {s_dg, s_ig};
        end
        check("rr_0", 32'(rr_seen[0]), 32'b10);
        check("rr_1", 32'(rr_seen[1]), 32'b01);
        check("rr_2", 32'(rr_seen[2]), 32'b10);
        check("rr_3", 32'(rr_seen[3]), 32'b01);
        imem_req = 0; dmem_req = 0;

        preload(32'h0100_0010, 32'h8001_FFFF);
        set_d(1, 0, 2'd1, 0, 32'h0100_0012, 0);
        cycle();
        check("half_signed", dmem_rdata, 32'hFFFF_8001);
        set_d(1, 0, 2'd1, 1, 32'h0100_0012, 0);
        cycle();
        check("half_unsigned", dmem_rdata, 32'h0000_8001);

        set_d(1, 1, 2'd2, 0, 32'h0100_0010, 32'h1122_3344);
        cycle();
        set_d(1, 1, 2'd0, 0, 32'h0100_0011, 32'h0000_00AB);
        cycle();
        dmem_req = 0; imem_req = 1; imem_addr = 32'h0100_0030;
        cycle();
        check("rmw_we", 32'(s_we), 32'd1);
        check("rmw_nogrant", 32'({s_ig, s_dg}), 32'd0);
        check("rmw_addr", s_addr, 32'h0100_0010);
        check("rmw_data", s_data, 32'h1122_AB44);
        cycle();
        imem_req = 0;

        set_d(1, 1, 2'd2, 0, 32'h0100_0006, 32'hCAFE_F00D);
        cycle();
        check("mis_gnt", 32'(s_dg), 32'd1);
        check("mis_nowrite", 32'(s_we), 32'd0);
        check("mis_err", 32'(dmem_err), 32'd1);
        dmem_req = 0;

        set_d(1, 1, 2'd1, 0, 32'h0100_0010, 32'h0000_5A5A);
        cycle();
        dmem_req = 0; rst = 1; imem_req = 1; imem_addr = 32'h0100_0004;
        cycle();
        check("rst_nowrite", 32'(s_we), 32'd0);
        rst = 0;
        cycle();
        check("rst_fetch_gnt", 32'(s_ig), 32'd1);
        check("rst_word_kept", phys_rd(32'h0100_0010), 32'h1122_AB44);
        imem_req = 0;

        for (int n = 0; n < 400; n++) begin
            if (!(imem_req && !g_i)) begin
                imem_req = ($urandom % 3) != 0;
                imem_addr = 32'h0100_0000 + ($urandom % 64);
            end
            if (!(dmem_req && !g_d)) begin
                set_d(($urandom % 3) != 0, $urandom % 2, 2'($urandom % 3), $urandom % 2,
                      32'h0100_0000 + ($urandom % 64), $urandom);
            end
            rst = ($urandom % 64) == 0;
            cycle();
        end
        rst = 0; imem_req = 0; dmem_req = 0;
        cycle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
